token_decoder: RTL and testbench
================================

Name: token_decoder

Overview:
- Inverse of the tokenizer encoder. Reads a zero-terminated stream of token codes from a code SRAM.
- Expands each code into its character string, looked up in the shared vocab SRAM.
- Writes the reconstructed zero-terminated character string into an output SRAM.
- Sits beside the encoder and connects to the same single-port synchronous `sram` instances (1-cycle read latency) through explicit address/data ports.

Parameters:
- ADDR_WIDTH, 4, address width of the code, vocab and output SRAMs.
- DATA_WIDTH, 8, width of characters and token codes.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin decode; sampled only in IDLE or DONE/ERR.
- code_addr  output  ADDR_WIDTH  code SRAM read address.
- code_rdata  input  DATA_WIDTH  code SRAM dout; valid 1 cycle after code_addr.
- vocab_addr  output  ADDR_WIDTH  vocab SRAM read address.
- vocab_rdata  input  DATA_WIDTH  vocab SRAM dout; valid 1 cycle after vocab_addr.
- out_addr  output  ADDR_WIDTH  output SRAM write address.
- out_wdata  output  DATA_WIDTH  output SRAM write data.
- out_we  output  1  output SRAM write enable, 1-cycle pulse per character.
- busy  output  1  high from the cycle after accepted start until DONE/ERR.
- done  output  1  sticky, set on successful completion.
- err  output  1  sticky, set on malformed input.
- char_count  output  ADDR_WIDTH  characters written, terminator excluded.

Behaviour:
- Reset: state IDLE. All addresses, out_wdata, out_we, busy, done, err and char_count are 0. Reset mid-operation aborts immediately; no further writes occur.
- Vocab format: entries are packed from address 0, each terminated by 0. Code k (k≥1) selects the k-th entry. Two consecutive 0s (an empty entry) mark the end of the vocab.
- Code stream format: codes from address 0; code 0 ends the stream.
- Registers: ac (code address), va (vocab address), ao (output address), target, idx.
- Every memory access uses two states: REQ drives the address, USE samples the data.
- States:
  - IDLE: on start, clear ac/ao/char_count/done/err; go to CREQ.
  - CREQ → CUSE.
    - code_rdata==0 → TERM.
    - Otherwise: target=code, idx=1, va=0; go to SREQ.
  - SREQ → SUSE (seek phase).
    - idx==target → COPY entry, va unchanged; go to VREQ.
    - Data==0 with the previous byte also 0, or va==0 with data 0 → ERR (code beyond vocab end).
    - Data==0 → idx+1.
    - va==2^ADDR_WIDTH-1 without a match → ERR.
    - Otherwise va+1; go to SREQ.
  - VREQ → VUSE (copy phase).
    - Data≠0: write data at ao with out_we=1, ao+1, char_count+1, va+1; go to VREQ.
    - Data==0: ac+1; go to CREQ.
  - TERM: write 0 at ao, out_we=1; go to DONE with done=1.
  - DONE / ERR: hold; busy=0; start restarts (clears flags).
- Overflow:
  - A non-terminator write when ao==2^ADDR_WIDTH-1 → ERR; no terminator slot remains.
  - ac wrapping past 2^ADDR_WIDTH-1 without a 0 code → ERR.
- start while busy is ignored. done and err are never both 1.
- Latency per token ≈ 2·(seek bytes) + 2·(length+1) cycles. Seek always restarts at vocab address 0.

Optional Feature:
- Macro: TOKEN_DECODER_LAST_HIT_EN.
- With the macro defined: the decoder keeps the last decoded code and the vocab start address of its entry. When the next code equals or exceeds the cached code, seek starts from the cached address/index instead of 0. Output data is identical to the macro-off build; only cycle counts shrink.
- Without the macro: seek always starts at va=0, idx=1.

Decomposition:
- Package `tokenizer_pkg`:
  - State enum `decoder_state` (IDLE, CREQ, CUSE, SREQ, SUSE, VREQ, VUSE, TERM, DONE, ERR).
  - Constants NULL_CHAR=0 and END_CODE=0.
  - Shared with the encoder.
- One natural sub-module: `vocab_seeker`. It performs the SREQ/SUSE scan (inputs target and start address/index; outputs entry address, found and err). The copy FSM stays in token_decoder.

Test Plan:
- Vocab "ab\0c\0de\0\0", codes [3,1,2,0], start pulse → out[0..5]="d","e","a","b","c",0; done=1, err=0, char_count=5; busy drops the cycle done rises.
- Codes [0] → single write of 0 at out[0]; done=1, char_count=0; no vocab reads issued.
- Same vocab, codes [4,0] → err=1, done=0, out_we never asserted.
- Output overflow: entry of 16 nonzero chars with ADDR_WIDTH=4, codes [1,0] → 15 writes (addresses 0–14), then err=1 on the attempted write at address 15.
- Reset asserted mid-COPY after 2 writes → all outputs 0 immediately. A subsequent start with codes [2,0] → out="c",0, done=1.
- Build with TOKEN_DECODER_LAST_HIT_EN, codes [1,3,3,0] → output identical to macro-off ("abdede",0); total cycles strictly fewer than the macro-off run.

Source files
------------

// File: rtl/tokenizer_pkg.sv
// Types and constants shared by the tokenizer encoder and token_decoder.
package tokenizer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CREQ,
    CUSE,
    SREQ,
    SUSE,
    VREQ,
    VUSE,
    TERM,
    DONE,
    ERR
  } decoder_state;

  localparam int NULL_CHAR = 0;
  localparam int END_CODE  = 0;

endpackage

// File: rtl/token_decoder_if.sv
// Bus between token_decoder (master) and its code/vocab/output SRAMs plus control.
interface token_decoder_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  // Control handshake: start is a level request, accepted only when the decoder
  // is not busy; busy rises the cycle after acceptance and falls exactly when
  // done or err rises. SRAM reads return data one cycle after the address.
  logic                  start;
  logic [ADDR_WIDTH-1:0] code_addr;
  logic [DATA_WIDTH-1:0] code_rdata;
  logic [ADDR_WIDTH-1:0] vocab_addr;
  logic [DATA_WIDTH-1:0] vocab_rdata;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_wdata;
  logic                  out_we;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] char_count;

  modport master (
    input  start, code_rdata, vocab_rdata,
    output code_addr, vocab_addr, out_addr, out_wdata, out_we,
           busy, done, err, char_count
  );

  modport slave (
    output start, code_rdata, vocab_rdata,
    input  code_addr, vocab_addr, out_addr, out_wdata, out_we,
           busy, done, err, char_count
  );
endinterface

// File: rtl/token_decoder_vocab_seeker.sv
// One step of the vocab seek scan: decides match / end-of-vocab / advance
// for the byte just read at va while looking for entry number target.
module vocab_seeker
  import tokenizer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] target,
  input  logic [ADDR_WIDTH-1:0] va,
  input  logic [DATA_WIDTH-1:0] idx,
  input  logic                  prev_zero,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  found,
  output logic                  seek_err,
  output logic [ADDR_WIDTH-1:0] nxt_va,
  output logic [DATA_WIDTH-1:0] nxt_idx
);
  logic byte_zero;
  logic end_hit;

  // A zero at an entry start is an empty entry, which marks the vocab end.
  assign byte_zero = (rdata == DATA_WIDTH'(NULL_CHAR));
  assign end_hit   = byte_zero && prev_zero;
  assign found     = !end_hit && (idx == target);
  assign seek_err  = end_hit || (!found && (va == '1));
  assign nxt_va    = va + ADDR_WIDTH'(1);
  assign nxt_idx   = byte_zero ? idx + DATA_WIDTH'(1) : idx;
endmodule

// File: rtl/token_decoder.sv
// Expands a zero-terminated code stream into characters via the vocab SRAM.
// Optional TOKEN_DECODER_LAST_HIT_EN resumes seeks from the last decoded entry.
module token_decoder
  import tokenizer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  token_decoder_if.master        bus,
  output decoder_state           state_dbg
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  decoder_state          state;
  logic [ADDR_WIDTH-1:0] ac;
  logic [ADDR_WIDTH-1:0] va;
  logic [ADDR_WIDTH-1:0] ao;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] idx;
  logic                  prev_zero;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_wdata_q;
  logic                  out_we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] count_q;

`ifdef TOKEN_DECODER_LAST_HIT_EN
  logic                  hit_valid;
  logic [DATA_WIDTH-1:0] hit_code;
  logic [ADDR_WIDTH-1:0] hit_va;
`endif

  logic                  found;
  logic                  seek_err;
  logic [ADDR_WIDTH-1:0] nxt_va;
  logic [DATA_WIDTH-1:0] nxt_idx;
  logic                  code_end;
  logic                  vbyte_zero;

  assign code_end   = (bus.code_rdata == DATA_WIDTH'(END_CODE));
  assign vbyte_zero = (bus.vocab_rdata == DATA_WIDTH'(NULL_CHAR));

  vocab_seeker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_seeker (
    .target    (target),
    .va        (va),
    .idx       (idx),
    .prev_zero (prev_zero),
    .rdata     (bus.vocab_rdata),
    .found     (found),
    .seek_err  (seek_err),
    .nxt_va    (nxt_va),
    .nxt_idx   (nxt_idx)
  );

  // Address registers drive the SRAMs directly; the write port is registered
  // separately so out_addr still names the slot while ao has moved on.
  assign bus.code_addr  = ac;
  assign bus.vocab_addr = va;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_wdata  = out_wdata_q;
  assign bus.out_we     = out_we_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.char_count = count_q;
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ac          <= '0;
      va          <= '0;
      ao          <= '0;
      target      <= '0;
      idx         <= '0;
      prev_zero   <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
`ifdef TOKEN_DECODER_LAST_HIT_EN
      hit_valid   <= 1'b0;
      hit_code    <= '0;
      hit_va      <= '0;
`endif
    end else begin
      out_we_q <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            ac      <= '0;
            ao      <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef TOKEN_DECODER_LAST_HIT_EN
            hit_valid <= 1'b0;
`endif
            state   <= CREQ;
          end
        end
        CREQ: state <= CUSE;
        CUSE: begin
          if (code_end) begin
            state <= TERM;
          end else begin
            target    <= bus.code_rdata;
            prev_zero <= 1'b1;
`ifdef TOKEN_DECODER_LAST_HIT_EN
            // Entries are ordered, so a code at or past the cached one can
            // resume the scan at the cached entry start.
            if (hit_valid && (bus.code_rdata >= hit_code)) begin
              va  <= hit_va;
              idx <= hit_code;
            end else begin
              va  <= '0;
              idx <= DATA_WIDTH'(1);
            end
`else
            va  <= '0;
            idx <= DATA_WIDTH'(1);
`endif
            state <= SREQ;
          end
        end
        SREQ: state <= SUSE;
        SUSE: begin
          if (seek_err) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= ERR;
          end else if (found) begin
`ifdef TOKEN_DECODER_LAST_HIT_EN
            hit_valid <= 1'b1;
            hit_code  <= target;
            hit_va    <= va;
`endif
            state <= VREQ;
          end else begin
            va        <= nxt_va;
            idx       <= nxt_idx;
            prev_zero <= vbyte_zero;
            state     <= SREQ;
          end
        end
        VREQ: state <= VUSE;
        VUSE: begin
          if (!vbyte_zero) begin
            // The last slot is reserved for the terminator.
            if (ao == ADDR_MAX) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= ERR;
            end else begin
              out_addr_q  <= ao;
              out_wdata_q <= bus.vocab_rdata;
              out_we_q    <= 1'b1;
              ao          <= ao + ADDR_WIDTH'(1);
              count_q     <= count_q + ADDR_WIDTH'(1);
              va          <= va + ADDR_WIDTH'(1);
              state       <= VREQ;
            end
          end else if (ac == ADDR_MAX) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= ERR;
          end else begin
            ac    <= ac + ADDR_WIDTH'(1);
            state <= CREQ;
          end
        end
        TERM: begin
          out_addr_q  <= ao;
          out_wdata_q <= DATA_WIDTH'(NULL_CHAR);
          out_we_q    <= 1'b1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_token_decoder.sv
// Directed testbench for token_decoder with behavioural code/vocab/output SRAMs.
module tb_token_decoder;
  import tokenizer_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
`ifdef TOKEN_DECODER_LAST_HIT_EN
  localparam int ABD_CYCLES = 44;
`else
  localparam int ABD_CYCLES = 54;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  token_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  decoder_state state_dbg;

  token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- SRAM models ----------------
  logic [DW-1:0] code_mem  [16];
  logic [DW-1:0] vocab_mem [16];
  logic [DW-1:0] out_mem   [16];
  logic          clear_out = 1'b1;
  int            wr_count = 0;
  int            va_moves = 0;
  logic [AW-1:0] va_prev = '0;

  always @(posedge clk) begin
    bus.code_rdata  <= code_mem[bus.code_addr];
    bus.vocab_rdata <= vocab_mem[bus.vocab_addr];
    if (clear_out) begin
      for (int i = 0; i < 16; i++) out_mem[i] <= 8'hEE;
    end else if (bus.out_we) begin
      out_mem[bus.out_addr] <= bus.out_wdata;
      wr_count++;
    end
    if (bus.vocab_addr !== va_prev) va_moves++;
    va_prev <= bus.vocab_addr;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(out_mem[i]), 32'(exp_q.pop_front()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_codes(input logic [DW-1:0] c0, c1, c2, c3);
    for (int i = 0; i < 16; i++) code_mem[i] = '0;
    code_mem[0] = c0; code_mem[1] = c1; code_mem[2] = c2; code_mem[3] = c3;
  endtask

  task automatic set_std_vocab();
    for (int i = 0; i < 16; i++) vocab_mem[i] = '0;
    vocab_mem[0] = 8'h61; vocab_mem[1] = 8'h62; vocab_mem[3] = 8'h63;
    vocab_mem[5] = 8'h64; vocab_mem[6] = 8'h65;
  endtask

  task automatic clear_output();
    clear_out = 1'b1;
    @(posedge clk);
    #1 clear_out = 1'b0;
  endtask

  task automatic run_decode(input int max_cycles, output int cycles);
    bus.start = 1'b1;
    @(posedge clk);
    cycles = 1;
    #1 bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    while (!(bus.done || bus.err) && cycles < max_cycles) begin
      @(posedge clk);
      cycles++;
      #1;
    end
    check("finished_in_budget", 32'(bus.done | bus.err), 32'd1);
    check("busy_low_at_finish", 32'(bus.busy), 32'd0);
    check("done_err_exclusive", 32'(bus.done & bus.err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int w0;
    int m0;
    int budget;

    bus.start = 1'b0;
    set_std_vocab();
    set_codes(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_code_addr", 32'(bus.code_addr), 32'd0);
    check("rst_vocab_addr", 32'(bus.vocab_addr), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_out_wdata", 32'(bus.out_wdata), 32'd0);
    check("rst_out_we", 32'(bus.out_we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_char_count", 32'(bus.char_count), 32'd0);
    clear_out = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // codes [3,1,2,0] -> "deabc"
    set_codes(8'd3, 8'd1, 8'd2, 8'd0);
    clear_output();
    w0 = wr_count;
    run_decode(300, cyc);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_err", 32'(bus.err), 32'd0);
    check("t1_char_count", 32'(bus.char_count), 32'd5);
    check("t1_writes", 32'(wr_count - w0), 32'd6);
    check("t1_cycles", 32'(cyc), 32'd48);
    exp_q = '{8'h64, 8'h65, 8'h61, 8'h62, 8'h63, 8'h00};
    check_out("t1_out");

    // codes [0] -> terminator only, no vocab scan
    set_codes(8'd0, 8'd0, 8'd0, 8'd0);
    clear_output();
    w0 = wr_count;
    m0 = va_moves;
    run_decode(50, cyc);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_char_count", 32'(bus.char_count), 32'd0);
    check("t2_writes", 32'(wr_count - w0), 32'd1);
    check("t2_vocab_idle", 32'(va_moves - m0), 32'd0);
    check("t2_cycles", 32'(cyc), 32'd4);
    exp_q = '{8'h00};
    check_out("t2_out");

    // codes [4,0] -> code beyond vocab end
    set_codes(8'd4, 8'd0, 8'd0, 8'd0);
    clear_output();
    w0 = wr_count;
    run_decode(200, cyc);
    check("t3_err", 32'(bus.err), 32'd1);
    check("t3_done", 32'(bus.done), 32'd0);
    check("t3_writes", 32'(wr_count - w0), 32'd0);
    check("t3_state", 32'(state_dbg), 32'(ERR));
    check("t3_cycles", 32'(cyc), 32'd21);

    // 16-char entry overflows the output SRAM
    for (int i = 0; i < 16; i++) vocab_mem[i] = 8'(8'h41 + i);
    set_codes(8'd1, 8'd0, 8'd0, 8'd0);
    clear_output();
    w0 = wr_count;
    run_decode(300, cyc);
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_done", 32'(bus.done), 32'd0);
    check("t4_char_count", 32'(bus.char_count), 32'd15);
    check("t4_writes", 32'(wr_count - w0), 32'd15);
    for (int i = 0; i < 15; i++) exp_q.push_back(8'(8'h41 + i));
    exp_q.push_back(8'hEE);
    check_out("t4_out");

    // reset in the middle of copying the second entry
    set_std_vocab();
    set_codes(8'd1, 8'd2, 8'd0, 8'd0);
    clear_output();
    w0 = wr_count;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    budget = 0;
    while (!((wr_count - w0) == 2 && state_dbg == VREQ) && budget < 200) begin
      @(posedge clk);
      budget++;
      #1;
    end
    check("t5_reached_copy", 32'(budget < 200), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", 32'(state_dbg), 32'(IDLE));
    check("t5_rst_out_we", 32'(bus.out_we), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_char_count", 32'(bus.char_count), 32'd0);
    check("t5_rst_vocab_addr", 32'(bus.vocab_addr), 32'd0);
    check("t5_rst_code_addr", 32'(bus.code_addr), 32'd0);
    check("t5_rst_out_addr", 32'(bus.out_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_writes_in_reset", 32'(wr_count - w0), 32'd2);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_codes(8'd2, 8'd0, 8'd0, 8'd0);
    clear_output();
    run_decode(200, cyc);
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_char_count", 32'(bus.char_count), 32'd1);
    exp_q = '{8'h63, 8'h00};
    check_out("t5_out");

    // codes [1,3,3,0] -> "abdede"; repeated code benefits from the seek cache
    set_codes(8'd1, 8'd3, 8'd3, 8'd0);
    clear_output();
    run_decode(300, cyc);
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_char_count", 32'(bus.char_count), 32'd6);
    check("t6_cycles", 32'(cyc), 32'(ABD_CYCLES));
    exp_q = '{8'h61, 8'h62, 8'h64, 8'h65, 8'h64, 8'h65, 8'h00};
    check_out("t6_out");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
